// File: rtl/ifu.sv
// Instruction fetch unit: PC, request/grant/response fetch to instruction memory,
// 2-entry instruction queue feeding IF/ID, redirect with in-flight response dropping.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_reg, pc_next;
   logic [1:0]  out_cnt_reg, out_cnt_next;
   logic [1:0]  drop_cnt_reg, drop_cnt_next;
   logic [1:0]  count_reg, count_next;
   logic        aq_wr_reg, aq_rd_reg;
   logic        iq_wr_reg, iq_rd_reg;
   logic [31:0] aq_mem [2];
   logic [31:0] iq_addr_mem [2];
   logic [31:0] iq_inst_mem [2];

   logic        pop, grant, resp_keep;
   logic [2:0]  occupancy;
   logic [31:0] jump_target;

   // Low address bits of the redirect target are ignored.
   assign jump_target = jump_addr_i & ~32'h0000_0003;

   assign inst_valid_o = (count_reg != 2'd0);
   assign pop          = inst_valid_o & ~hold_i & ~jump_en_i;
   // Slots committed after this cycle's pop; a request only goes out if one stays free.
   assign occupancy    = {1'b0, out_cnt_reg} + {1'b0, count_reg} - {2'b00, pop};
   assign imem_req_o   = rst & ~jump_en_i & (occupancy < 3'd2);
   assign imem_addr_o  = pc_reg;
   assign grant        = imem_req_o & imem_gnt_i;
   assign resp_keep    = imem_rvalid_i & ~jump_en_i & (drop_cnt_reg == 2'd0);

   assign inst_o      = inst_valid_o ? iq_inst_mem[iq_rd_reg] : NOP;
   assign inst_addr_o = inst_valid_o ? iq_addr_mem[iq_rd_reg] : 32'h0000_0000;

   always_comb begin
      pc_next       = pc_reg;
      out_cnt_next  = out_cnt_reg + {1'b0, grant} - {1'b0, imem_rvalid_i};
      drop_cnt_next = drop_cnt_reg;
      count_next    = count_reg + {1'b0, resp_keep} - {1'b0, pop};
      if (jump_en_i) begin
         pc_next       = jump_target;
         drop_cnt_next = out_cnt_reg - {1'b0, imem_rvalid_i};
         count_next    = 2'd0;
      end else begin
         if (grant)
            pc_next = pc_reg + 32'd4;
         if (imem_rvalid_i && drop_cnt_reg != 2'd0)
            drop_cnt_next = drop_cnt_reg - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_reg       <= RESET_PC;
         out_cnt_reg  <= 2'd0;
         drop_cnt_reg <= 2'd0;
         count_reg    <= 2'd0;
         aq_wr_reg    <= 1'b0;
         aq_rd_reg    <= 1'b0;
         iq_wr_reg    <= 1'b0;
         iq_rd_reg    <= 1'b0;
      end else begin
         pc_reg       <= pc_next;
         out_cnt_reg  <= out_cnt_next;
         drop_cnt_reg <= drop_cnt_next;
         count_reg    <= count_next;
         if (grant)
            aq_wr_reg <= ~aq_wr_reg;
         if (imem_rvalid_i)
            aq_rd_reg <= ~aq_rd_reg;
         if (jump_en_i) begin
            iq_rd_reg <= iq_wr_reg;
         end else begin
            if (resp_keep)
               iq_wr_reg <= ~iq_wr_reg;
            if (pop)
               iq_rd_reg <= ~iq_rd_reg;
         end
      end
   end

   // Queue storage carries no reset; occupancy is tracked by the counters above.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (grant && aq_wr_reg == 1'(gi))
               aq_mem[gi] <= pc_reg;
            if (resp_keep && iq_wr_reg == 1'(gi)) begin
               iq_addr_mem[gi] <= aq_mem[aq_rd_reg];
               iq_inst_mem[gi] <= imem_rdata_i;
            end
         end
      end
   endgenerate

endmodule
